// File: rtl/gpio_param16.sv
// gpio_param16: parametrised APB GPIO with per-pin direction, a two-flop
// input synchroniser and level/edge/both-edge interrupts with a RW1C status.
// Optional input debounce is enabled by defining GPIO16_DEBOUNCE_EN.
module gpio_param16 #(
  parameter int NUM_PINS  = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic                pclk16,
  input  logic                p_reset16,
  input  logic                psel16,
  input  logic                penable16,
  input  logic                pwrite16,
  input  logic [5:0]          paddr16,
  input  logic [31:0]         pwdata16,
  output logic [31:0]         prdata16,
  input  logic [NUM_PINS-1:0] gpio_pin_in16,
  input  logic [NUM_PINS-1:0] tri_state_enable16,
  output logic [NUM_PINS-1:0] gpio_pin_out16,
  output logic [NUM_PINS-1:0] n_gpio_pin_oe16,
  output logic                gpio_int16
);

  localparam logic [3:0] ADDR_DOUT     = 4'h0;
  localparam logic [3:0] ADDR_DIR      = 4'h1;
  localparam logic [3:0] ADDR_DIN      = 4'h2;
  localparam logic [3:0] ADDR_INT_EN   = 4'h3;
  localparam logic [3:0] ADDR_INT_TYPE = 4'h4;
  localparam logic [3:0] ADDR_INT_POL  = 4'h5;
  localparam logic [3:0] ADDR_INT_BOTH = 4'h6;
  localparam logic [3:0] ADDR_INT_STAT = 4'h7;

  logic [NUM_PINS-1:0] dout_reg;
  logic [NUM_PINS-1:0] dir_reg;
  logic [NUM_PINS-1:0] int_en;
  logic [NUM_PINS-1:0] int_type;
  logic [NUM_PINS-1:0] int_pol;
  logic [NUM_PINS-1:0] int_both;
  logic [NUM_PINS-1:0] int_stat;
  logic [NUM_PINS-1:0] sync1;
  logic [NUM_PINS-1:0] sync2;
  logic [NUM_PINS-1:0] din;
  logic [NUM_PINS-1:0] din_q;

  logic                wr_en;
  logic                rd_setup;
  logic [3:0]          word_addr;
  logic [NUM_PINS-1:0] wr_data;
  logic [NUM_PINS-1:0] stat_clr;
  logic [NUM_PINS-1:0] edge_evt;
  logic [NUM_PINS-1:0] level_evt;
  logic [31:0]         rd_word;
  logic                unused_bits;

  assign word_addr = paddr16[5:2];
  assign wr_data   = pwdata16[NUM_PINS-1:0];
  assign wr_en     = psel16 & penable16 & pwrite16;
  assign rd_setup  = psel16 & ~penable16 & ~pwrite16;
  assign stat_clr  = (wr_en && word_addr == ADDR_INT_STAT) ? wr_data : '0;
  assign unused_bits = ^{paddr16[1:0], pwdata16, 8'(DB_CYCLES)};

  assign gpio_pin_out16  = dout_reg;
  assign n_gpio_pin_oe16 = ~(dir_reg & ~tri_state_enable16);

  // Configuration registers commit during the APB access phase
  always_ff @(posedge pclk16 or posedge p_reset16) begin
    if (p_reset16) begin
      dout_reg <= '0;
      dir_reg  <= '0;
      int_en   <= '0;
      int_type <= '0;
      int_pol  <= '0;
      int_both <= '0;
    end else if (wr_en) begin
      case (word_addr)
        ADDR_DOUT:     dout_reg <= wr_data;
        ADDR_DIR:      dir_reg  <= wr_data;
        ADDR_INT_EN:   int_en   <= wr_data;
        ADDR_INT_TYPE: int_type <= wr_data;
        ADDR_INT_POL:  int_pol  <= wr_data;
        ADDR_INT_BOTH: int_both <= wr_data;
        default: ;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous pins, plus the previous DIN for edges
  always_ff @(posedge pclk16 or posedge p_reset16) begin
    if (p_reset16) begin
      sync1 <= '0;
      sync2 <= '0;
      din_q <= '0;
    end else begin
      sync1 <= gpio_pin_in16;
      sync2 <= sync1;
      din_q <= din;
    end
  end

`ifdef GPIO16_DEBOUNCE_EN
  logic [7:0] db_cnt [NUM_PINS];

  // DIN follows the synchronised pin only after it has differed for DB_CYCLES cycles
  always_ff @(posedge pclk16 or posedge p_reset16) begin
    if (p_reset16) begin
      din <= '0;
      for (int i = 0; i < NUM_PINS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PINS; i++) begin
        if (sync2[i] == din[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == 8'(DB_CYCLES - 1)) begin
          din[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  assign din = sync2;
`endif

  // Per-pin event sources; a level source is held off during its own clear so the
  // bit visibly drops for one cycle and then re-sets, while edge events beat a clear
  always_comb begin
    edge_evt  = int_en & int_type &
                ((int_both & (din ^ din_q)) |
                 (~int_both & int_pol & din & ~din_q) |
                 (~int_both & ~int_pol & ~din & din_q));
    level_evt = int_en & ~int_type & ~(din ^ int_pol);
  end

  // Interrupt status (write-1-to-clear) and the registered interrupt line
  always_ff @(posedge pclk16 or posedge p_reset16) begin
    if (p_reset16) begin
      int_stat   <= '0;
      gpio_int16 <= 1'b0;
    end else begin
      int_stat   <= (int_stat & ~stat_clr) | edge_evt | (level_evt & ~stat_clr);
      gpio_int16 <= |int_stat;
    end
  end

  // Read mux; unused upper bits and unmapped offsets read as zero
  always_comb begin
    rd_word = '0;
    case (word_addr)
      ADDR_DOUT:     rd_word[NUM_PINS-1:0] = dout_reg;
      ADDR_DIR:      rd_word[NUM_PINS-1:0] = dir_reg;
      ADDR_DIN:      rd_word[NUM_PINS-1:0] = din;
      ADDR_INT_EN:   rd_word[NUM_PINS-1:0] = int_en;
      ADDR_INT_TYPE: rd_word[NUM_PINS-1:0] = int_type;
      ADDR_INT_POL:  rd_word[NUM_PINS-1:0] = int_pol;
      ADDR_INT_BOTH: rd_word[NUM_PINS-1:0] = int_both;
      ADDR_INT_STAT: rd_word[NUM_PINS-1:0] = int_stat;
      default:       rd_word = '0;
    endcase
  end

  // Read data is captured in the setup phase, held through access, then zeroed
  always_ff @(posedge pclk16 or posedge p_reset16) begin
    if (p_reset16) begin
      prdata16 <= '0;
    end else if (rd_setup) begin
      prdata16 <= rd_word;
    end else begin
      prdata16 <= '0;
    end
  end

endmodule

// File: tb/tb_gpio_param16.sv
// tb_gpio_param16: directed self-checking bench for gpio_param16 (16 pins).
module tb_gpio_param16;

  localparam int NP = 16;
`ifdef GPIO16_DEBOUNCE_EN
  localparam int DBX = 4;
`else
  localparam int DBX = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [5:0]    paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic [NP-1:0] pin_in, tse, pin_out, n_oe;
  logic          irq;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rd;

  gpio_param16 #(.NUM_PINS(NP), .DB_CYCLES(4)) dut (
    .pclk16(clk), .p_reset16(rst), .psel16(psel), .penable16(penable),
    .pwrite16(pwrite), .paddr16(paddr), .pwdata16(pwdata), .prdata16(prdata),
    .gpio_pin_in16(pin_in), .tri_state_enable16(tse),
    .gpio_pin_out16(pin_out), .n_gpio_pin_oe16(n_oe), .gpio_int16(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [5:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] exp_zero;
    exp_zero = 32'h0;
    rst = 1'b1;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    pin_in = '0; tse = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    if (n_oe !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL reset_n_oe got %h expected ffff", n_oe); end
    vectors++;
    if (pin_out !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_pin_out got %h expected 0000", pin_out); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_irq got %b expected 0", irq); end
    vectors++;
    for (int i = 0; i < 9; i++) begin
      apb_read(6'(i * 4), rd);
      if (rd !== exp_zero) begin miscompares++; $display("[TB] FAIL reset_read_%0h got %h expected %h", i * 4, rd, exp_zero); end
      vectors++;
    end
  endtask

  task automatic test_output_drive;
    apb_write(6'h04, 32'h0000_00FF);
    apb_write(6'h00, 32'h0000_A5A5);
    if (pin_out !== 16'hA5A5) begin miscompares++; $display("[TB] FAIL dout_latency got %h expected a5a5", pin_out); end
    vectors++;
    tse = 16'h000F;
    tick(1);
    if (n_oe !== 16'hFF0F) begin miscompares++; $display("[TB] FAIL n_oe got %h expected ff0f", n_oe); end
    vectors++;
    apb_read(6'h04, rd);
    if (rd !== 32'h0000_00FF) begin miscompares++; $display("[TB] FAIL dir_read got %h expected 000000ff", rd); end
    vectors++;
    apb_write(6'h14, 32'hFFFF_FFFF);
    apb_read(6'h14, rd);
    if (rd !== 32'h0000_FFFF) begin miscompares++; $display("[TB] FAIL upper_bits got %h expected 0000ffff", rd); end
    vectors++;
    apb_write(6'h14, 32'h0);
    apb_write(6'h3C, 32'hFFFF_FFFF);
    apb_read(6'h3C, rd);
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL unmapped got %h expected 0", rd); end
    vectors++;
    pin_in = 16'h1234;
    tick(4 + DBX);
    apb_read(6'h08, rd);
    if (rd !== 32'h0000_1234) begin miscompares++; $display("[TB] FAIL din_read got %h expected 00001234", rd); end
    vectors++;
    pin_in = '0;
    tick(4 + DBX);
  endtask

  task automatic test_rising_edge;
    apb_write(6'h10, 32'h08);
    apb_write(6'h14, 32'h08);
    apb_write(6'h0C, 32'h08);
    pin_in[3] = 1'b1;
    tick(3 + DBX);
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL rise_irq_c3 got %b expected 0", irq); end
    vectors++;
    tick(1);
    if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL rise_irq_c4 got %b expected 1", irq); end
    vectors++;
    apb_read(6'h1C, rd);
    if (rd !== 32'h8) begin miscompares++; $display("[TB] FAIL rise_stat got %h expected 8", rd); end
    vectors++;
    apb_write(6'h1C, 32'h8);
    if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL clr_irq_hold got %b expected 1", irq); end
    vectors++;
    tick(1);
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_irq_drop got %b expected 0", irq); end
    vectors++;
  endtask

  task automatic test_level;
    apb_write(6'h14, 32'h09);
    pin_in[0] = 1'b1;
    tick(3 + DBX);
    apb_write(6'h0C, 32'h09);
    tick(3);
    if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL level_irq got %b expected 1", irq); end
    vectors++;
    apb_write(6'h1C, 32'h1);
    tick(1);
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL level_clr_gap got %b expected 0", irq); end
    vectors++;
    tick(1);
    if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL level_reset got %b expected 1", irq); end
    vectors++;
    apb_write(6'h0C, 32'h08);
    apb_read(6'h1C, rd);
    if (rd !== 32'h1) begin miscompares++; $display("[TB] FAIL pending_after_disable got %h expected 1", rd); end
    vectors++;
    apb_write(6'h1C, 32'h1);
    pin_in[0] = 1'b0;
    tick(2);
    apb_read(6'h1C, rd);
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL level_cleared got %h expected 0", rd); end
    vectors++;
  endtask

  task automatic test_clear_collision;
    pin_in[3] = 1'b0;
    tick(4 + DBX);
    pin_in[3] = 1'b1;
    tick(5 + DBX);
    pin_in[3] = 1'b0;
    tick(4 + DBX);
    pin_in[3] = 1'b1;
    if (DBX > 0) tick(DBX);
    apb_write(6'h1C, 32'h8);
    apb_read(6'h1C, rd);
    if (rd !== 32'h8) begin miscompares++; $display("[TB] FAIL collision_stat got %h expected 8", rd); end
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL collision_irq got %b expected 1", irq); end
    vectors++;
    apb_write(6'h1C, 32'h8);
    tick(2);
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL collision_cleanup got %b expected 0", irq); end
    vectors++;
  endtask

  task automatic test_both_edges;
    apb_write(6'h0C, 32'h20);
    apb_write(6'h10, 32'h28);
    apb_write(6'h18, 32'h20);
    pin_in[5] = 1'b1;
    tick(5 + DBX);
    apb_read(6'h1C, rd);
    if (rd !== 32'h20) begin miscompares++; $display("[TB] FAIL both_rise_stat got %h expected 20", rd); end
    vectors++;
    apb_write(6'h1C, 32'h20);
    tick(1);
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL both_between got %b expected 0", irq); end
    vectors++;
    pin_in[5] = 1'b0;
    tick(5 + DBX);
    if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL both_fall_irq got %b expected 1", irq); end
    vectors++;
    apb_read(6'h1C, rd);
    if (rd !== 32'h20) begin miscompares++; $display("[TB] FAIL both_fall_stat got %h expected 20", rd); end
    vectors++;
    apb_write(6'h1C, 32'h20);
    tick(2);
  endtask

`ifdef GPIO16_DEBOUNCE_EN
  task automatic test_debounce;
    apb_write(6'h0C, 32'h80);
    apb_write(6'h10, 32'hA8);
    apb_write(6'h18, 32'hA0);
    pin_in[7] = 1'b1;
    tick(3);
    pin_in[7] = 1'b0;
    tick(12);
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_irq got %b expected 0", irq); end
    vectors++;
    apb_read(6'h08, rd);
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL glitch_din got %h expected 0", rd); end
    vectors++;
    pin_in[7] = 1'b1;
    tick(7);
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL pulse_irq_c7 got %b expected 0", irq); end
    vectors++;
    tick(1);
    if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL pulse_irq_c8 got %b expected 1", irq); end
    vectors++;
    pin_in[7] = 1'b0;
    tick(10);
    apb_write(6'h1C, 32'h80);
    apb_write(6'h0C, 32'h0);
    tick(2);
  endtask
`endif

  task automatic test_reset_mid_transfer;
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 6'h00; pwdata = 32'h1111;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rst = 1'b1;
    #1;
    if (pin_out !== 16'h0) begin miscompares++; $display("[TB] FAIL midreset_pin_out got %h expected 0000", pin_out); end
    vectors++;
    if (n_oe !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL midreset_n_oe got %h expected ffff", n_oe); end
    vectors++;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick(1);
    rst = 1'b0;
    apb_read(6'h00, rd);
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL midreset_dout got %h expected 0", rd); end
    vectors++;
    apb_read(6'h10, rd);
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL midreset_type got %h expected 0", rd); end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_output_drive();
    test_rising_edge();
    test_level();
    test_clear_collision();
    test_both_edges();
`ifdef GPIO16_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
